// File: rtl/matdet3_seq.sv
// matdet3_seq: 3x3 determinant modulo 2^DATA_WIDTH.
// One multiplier and one add/sub unit are shared over nine CALC steps.
module matdet3_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int MATRIX_SIZE = 9
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [MATRIX_SIZE*DATA_WIDTH-1:0] a,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             det,
    output logic                              busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_step, w_step_nxt;
    logic [DATA_WIDTH-1:0] r_e [MATRIX_SIZE];
    logic [DATA_WIDTH-1:0] r_m, r_acc, r_det;
    logic [DATA_WIDTH-1:0] w_op_x, w_op_y, w_prod, w_base, w_sum;
    logic                  w_accept, w_calc, w_sub, w_to_acc, w_base_m, w_base_acc;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign det       = r_det;
    assign w_accept  = in_ready & in_valid;
    assign w_calc    = (r_state == CALC);

    // Steps 0/3/6 start a 2x2 minor, 1/4/7 finish it, 2/5/8 fold it into acc.
    always_comb begin
        w_op_x = '0;
        w_op_y = '0;
        case (r_step)
            4'd0: begin w_op_x = r_e[4]; w_op_y = r_e[8]; end
            4'd1: begin w_op_x = r_e[5]; w_op_y = r_e[7]; end
            4'd2: begin w_op_x = r_e[0]; w_op_y = r_m;    end
            4'd3: begin w_op_x = r_e[3]; w_op_y = r_e[8]; end
            4'd4: begin w_op_x = r_e[5]; w_op_y = r_e[6]; end
            4'd5: begin w_op_x = r_e[1]; w_op_y = r_m;    end
            4'd6: begin w_op_x = r_e[3]; w_op_y = r_e[7]; end
            4'd7: begin w_op_x = r_e[4]; w_op_y = r_e[6]; end
            4'd8: begin w_op_x = r_e[2]; w_op_y = r_m;    end
            default: ;
        endcase
    end

    assign w_prod     = w_op_x * w_op_y;
    assign w_to_acc   = (r_step == 4'd2) || (r_step == 4'd5) || (r_step == 4'd8);
    assign w_base_m   = (r_step == 4'd1) || (r_step == 4'd4) || (r_step == 4'd7);
    assign w_base_acc = (r_step == 4'd5) || (r_step == 4'd8);
    assign w_sub      = w_base_m || (r_step == 4'd5);
    assign w_base     = w_base_m ? r_m : (w_base_acc ? r_acc : '0);
    assign w_sum      = w_sub ? w_base - w_prod : w_base + w_prod;

    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            IDLE: if (in_valid) begin
                w_state_nxt = CALC;
                w_step_nxt  = '0;
            end
            CALC: begin
                w_step_nxt = r_step + 4'd1;
                if (r_step == 4'd8) begin
                    w_state_nxt = DONE;
                    w_step_nxt  = '0;
                end
            end
            DONE: if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_step  <= '0;
            r_m     <= '0;
            r_acc   <= '0;
            r_det   <= '0;
            for (int k = 0; k < MATRIX_SIZE; k++) r_e[k] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            if (w_accept)
                for (int k = 0; k < MATRIX_SIZE; k++) r_e[k] <= a[k*DATA_WIDTH +: DATA_WIDTH];
            if (w_calc && !w_to_acc) r_m <= w_sum;
            if (w_calc && w_to_acc) r_acc <= w_sum;
            if (w_calc && r_step == 4'd8) r_det <= w_sum;
        end
    end
endmodule

// File: tb/tb_matdet3_seq.sv
// tb_matdet3_seq: directed vectors against a cycle-level behavioural model of matdet3_seq.
module tb_matdet3_seq;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [71:0] a = '0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [7:0]  det;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    // model: phase 0 idle, 1 computing, 2 result offered
    int         m_phase = 0;
    int         m_cnt = 0;
    logic [7:0] m_res = '0;
    logic [7:0] m_det = '0;

    matdet3_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a),
        .out_valid(out_valid), .out_ready(out_ready), .det(det), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [71:0] mk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
        return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    function automatic logic [7:0] det3(input logic [71:0] m);
        int e [9];
        int d;
        for (int k = 0; k < 9; k++) e[k] = int'(m[k*8 +: 8]);
        d = e[0]*(e[4]*e[8] - e[5]*e[7]) - e[1]*(e[3]*e[8] - e[5]*e[6]) + e[2]*(e[3]*e[7] - e[4]*e[6]);
        return d[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_det   <= '0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase <= 1;
                m_cnt   <= 0;
                m_res   <= det3(a);
            end
        end else if (m_phase == 1) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 8) begin
                m_phase <= 2;
                m_det   <= m_res;
            end
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_phase == 0);
        chk("out_valid", out_valid, m_phase == 2);
        chk("busy", busy, m_phase != 0);
        chk("det", det, m_det);
    end

    task automatic send(input logic [71:0] m);
        int n = 0;
        a = m;
        in_valid = 1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid = 0;
    endtask

    task automatic wait_out(input string name, input logic [7:0] exp);
        int n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_lat"}, cyc - acc_cyc, 9);
        chk({name, "_det"}, det, exp);
    endtask

    logic [71:0] m_id, m_123, m_16, m_sing, m_ff, m_3;
    int t1, n;

    initial begin
        m_id   = mk(1, 0, 0, 0, 1, 0, 0, 0, 1);
        m_123  = mk(1, 2, 3, 4, 5, 6, 7, 8, 10);
        m_16   = mk(16, 0, 0, 0, 16, 0, 0, 0, 1);
        m_sing = mk(2, 0, 1, 1, 3, 2, 1, 1, 1);
        m_ff   = {9{8'hFF}};
        m_3    = mk(3, 0, 0, 0, 1, 0, 0, 0, 1);
        chk("model_id", det3(m_id), 8'h01);
        chk("model_123", det3(m_123), 8'hFD);
        chk("model_16", det3(m_16), 8'h00);
        chk("model_sing", det3(m_sing), 8'h00);
        chk("model_ff", det3(m_ff), 8'h00);
        chk("model_3", det3(m_3), 8'h03);
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_det", det, 0);
        @(posedge clk); #1 rst_n = 1;
        send(m_id);
        chk("id_in_ready_low", in_ready, 0);
        chk("id_busy", busy, 1);
        wait_out("id", 8'h01);
        @(posedge clk); #1;
        out_ready = 0;
        send(m_123);
        wait_out("m123", 8'hFD);
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_det", det, 8'hFD);
        end
        out_ready = 1;
        @(posedge clk); #1;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
        send(m_16);
        wait_out("m16", 8'h00);
        send(m_sing);
        wait_out("sing", 8'h00);
        send(m_ff);
        wait_out("ff", 8'h00);
        @(posedge clk); #1;
        a = m_3;
        in_valid = 1;
        @(posedge clk); #1;
        t1 = cyc;
        acc_cyc = cyc;
        a = m_123;
        wait_out("b2b1", 8'h03);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (busy && n < 50);
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!busy && n < 50);
        chk("b2b_interval", cyc - t1, 11);
        acc_cyc = cyc;
        in_valid = 0;
        wait_out("b2b2", 8'hFD);
        @(posedge clk); #1;
        send(m_16);
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_det", det, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1 rst_n = 1;
        send(m_id);
        wait_out("post_rst", 8'h01);
        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
